// File: rtl/key_led_reader.sv
// key_led_reader: time-shares one open-drain pad between an LED and a key, sampling and debouncing the key.
module key_led_reader #(
    parameter int SAMPLE_DIV  = 50000,
    parameter int RELEASE_CYC = 50,
    parameter int DEBOUNCE_N  = 20
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic led_on,
    input  logic pin_in,
    output logic pin_oe,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic sample_stb
);
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int RW = $clog2(RELEASE_CYC);

    typedef enum logic [1:0] {DRIVE, RELEASE, SAMPLE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [DW-1:0] div_q, div_d;
    logic [RW-1:0] rel_q, rel_d;
    logic [7:0]    cnt_q, cnt_d, cnt_inc;
    logic          level_q, level_d, prev_q, prev_d;
    logic          press_q, press_d, release_q, release_d, stb_q, stb_d;
    logic          pin_s, sample, is_sample, div_last, rel_last, flip;

    always_comb begin
        sync_d    = {sync_q[0], pin_in};
        pin_s     = sync_q[1];
        sample    = ~pin_s;
        is_sample = state_q == SAMPLE;
        div_last  = div_q == DW'(SAMPLE_DIV - 1);
        rel_last  = rel_q == RW'(RELEASE_CYC - 1);
        div_d     = div_last ? '0 : div_q + 1'b1;
        state_d   = (state_q == DRIVE && div_last)     ? RELEASE :
                    (state_q == RELEASE && rel_last)   ? SAMPLE  :
                    is_sample                          ? DRIVE   : state_q;
        rel_d     = (state_q == RELEASE && !rel_last) ? rel_q + 1'b1 : '0;
        // Only disagreeing samples advance the counter; reaching the threshold flips the level.
        cnt_inc   = cnt_q + 8'd1;
        flip      = is_sample && sample != level_q && cnt_inc == 8'(DEBOUNCE_N);
        cnt_d     = !is_sample ? cnt_q : (sample == level_q || flip) ? '0 : cnt_inc;
        level_d   = flip ? sample : level_q;
        prev_d    = level_q;
        press_d   = level_q & ~prev_q;
        release_d = ~level_q & prev_q;
        stb_d     = is_sample;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q   <= DRIVE;
            sync_q    <= 2'b11;
            div_q     <= '0;
            rel_q     <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            prev_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            div_q     <= div_d;
            rel_q     <= rel_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            prev_q    <= prev_d;
            press_q   <= press_d;
            release_q <= release_d;
            stb_q     <= stb_d;
        end
    end

    assign pin_oe      = ~reset & (state_q == DRIVE) & led_on;
    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign sample_stb  = stb_q;
endmodule

// File: tb/tb_key_led_reader.sv
// tb_key_led_reader: directed scenarios against a pad model where the key or the LED pulls the line low.
module tb_key_led_reader;
    localparam int SD = 100;
    localparam int RC = 8;
    localparam int DN = 3;
    localparam int FIRST = SD + RC + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic led_on = 1'b1;
    logic key = 1'b0;
    logic pin_in, pin_oe, key_level, key_press, key_release, sample_stb;
    int pass_cnt = 0;
    int total = 0;
    int press_cnt = 0;
    int rel_cnt = 0;
    int both_cnt = 0;

    assign pin_in = ~(pin_oe | key);

    always #5 clk = ~clk;

    key_led_reader #(.SAMPLE_DIV(SD), .RELEASE_CYC(RC), .DEBOUNCE_N(DN)) dut (
        .sys_clk(clk), .reset(reset), .led_on(led_on), .pin_in(pin_in),
        .pin_oe(pin_oe), .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .sample_stb(sample_stb)
    );

    always @(negedge clk) begin
        if (key_press === 1'b1) press_cnt++;
        if (key_release === 1'b1) rel_cnt++;
        if (key_press === 1'b1 && key_release === 1'b1) both_cnt++;
    end

    task automatic wait_stb(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (sample_stb !== 1'b1 && cyc < 4 * SD);
        if (sample_stb !== 1'b1) begin
            total++;
            $display("FAIL stb_timeout: no sample_stb within %0d cycles", cyc);
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({pin_oe, key_level, key_press, key_release, sample_stb} !== 5'b0)
            $display("FAIL reset_outputs: got %b expected 00000",
                     {pin_oe, key_level, key_press, key_release, sample_stb});
        else pass_cnt++;
    endtask

    task automatic test_first_stb();
        int c;
        reset = 1'b0;
        wait_stb(c);
        total++;
        if (c !== FIRST) $display("FAIL first_stb: latency %0d expected %0d", c, FIRST);
        else pass_cnt++;
    endtask

    task automatic test_steady();
        int released = 0, run = 0, maxrun = 0, stbs = 0, lvl = 0, p0 = press_cnt, r0 = rel_cnt;
        for (int i = 0; i < 3 * SD; i++) begin
            @(negedge clk);
            if (pin_oe === 1'b0) begin
                released++;
                run++;
                if (run > maxrun) maxrun = run;
            end else run = 0;
            if (sample_stb === 1'b1) stbs++;
            if (key_level !== 1'b0) lvl++;
        end
        #1;
        total++;
        if (released !== 3 * (RC + 1)) $display("FAIL steady_released: got %0d expected %0d", released, 3 * (RC + 1));
        else pass_cnt++;
        total++;
        if (maxrun !== RC + 1) $display("FAIL steady_window: got %0d expected %0d", maxrun, RC + 1);
        else pass_cnt++;
        total++;
        if (stbs !== 3) $display("FAIL steady_stb: got %0d expected 3", stbs);
        else pass_cnt++;
        total++;
        if (lvl !== 0) $display("FAIL steady_level: got %0d high cycles expected 0", lvl);
        else pass_cnt++;
        total++;
        if (press_cnt - p0 + rel_cnt - r0 !== 0)
            $display("FAIL steady_pulses: got %0d expected 0", press_cnt - p0 + rel_cnt - r0);
        else pass_cnt++;
    endtask

    task automatic test_clean_press();
        int c, p0 = press_cnt;
        key = 1'b1;
        wait_stb(c);
        wait_stb(c);
        total++;
        if (press_cnt !== p0 || key_level !== 1'b0)
            $display("FAIL press_early: presses %0d level %b expected 0 0", press_cnt - p0, key_level);
        else pass_cnt++;
        wait_stb(c);
        total++;
        if (key_level !== 1'b1 || key_press !== 1'b0)
            $display("FAIL press_level: level %b press %b expected 1 0", key_level, key_press);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (key_press !== 1'b1) $display("FAIL press_pulse: got %b expected 1", key_press);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total++;
        if (press_cnt - p0 !== 1) $display("FAIL press_count: got %0d expected 1", press_cnt - p0);
        else pass_cnt++;
    endtask

    task automatic test_release();
        int c, p0 = press_cnt, r0 = rel_cnt;
        key = 1'b0;
        wait_stb(c);
        wait_stb(c);
        total++;
        if (key_level !== 1'b1) $display("FAIL release_hold: got %b expected 1", key_level);
        else pass_cnt++;
        wait_stb(c);
        total++;
        if (key_level !== 1'b0) $display("FAIL release_level: got %b expected 0", key_level);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (key_release !== 1'b1) $display("FAIL release_pulse: got %b expected 1", key_release);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total++;
        if (rel_cnt - r0 !== 1 || press_cnt !== p0)
            $display("FAIL release_count: releases %0d presses %0d expected 1 0", rel_cnt - r0, press_cnt - p0);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int c, p0 = press_cnt;
        for (int i = 0; i < 6; i++) begin
            key = pat[i];
            wait_stb(c);
            total++;
            if (i < 5) begin
                if (press_cnt !== p0 || key_level !== 1'b0)
                    $display("FAIL bounce_early_%0d: presses %0d level %b expected 0 0", i, press_cnt - p0, key_level);
                else pass_cnt++;
            end else begin
                if (key_level !== 1'b1) $display("FAIL bounce_level: got %b expected 1", key_level);
                else pass_cnt++;
            end
        end
        @(negedge clk);
        total++;
        if (key_press !== 1'b1) $display("FAIL bounce_pulse: got %b expected 1", key_press);
        else pass_cnt++;
    endtask

    task automatic test_led_toggle();
        int c, bad = 0;
        led_on = 1'b1;
        wait_stb(c);
        repeat (SD - RC - 1) @(negedge clk);
        for (int i = 0; i < RC + 1; i++) begin
            if (pin_oe !== 1'b0) bad++;
            led_on = ~led_on;
            @(negedge clk);
        end
        total++;
        if (bad !== 0) $display("FAIL toggle_released: %0d driven cycles expected 0", bad);
        else pass_cnt++;
        total++;
        if (sample_stb !== 1'b1) $display("FAIL toggle_align: stb %b expected 1", sample_stb);
        else pass_cnt++;
        led_on = 1'b1;
        #1;
        total++;
        if (pin_oe !== 1'b1) $display("FAIL toggle_follow_on: got %b expected 1", pin_oe);
        else pass_cnt++;
        led_on = 1'b0;
        #1;
        total++;
        if (pin_oe !== 1'b0) $display("FAIL toggle_follow_off: got %b expected 0", pin_oe);
        else pass_cnt++;
        led_on = 1'b1;
    endtask

    task automatic test_reset_mid();
        int c, p0;
        key = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_stb(c);
        wait_stb(c);
        p0 = press_cnt;
        repeat (SD - RC + 3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({pin_oe, key_level, key_press, key_release, sample_stb} !== 5'b0)
            $display("FAIL midreset_outputs: got %b expected 00000",
                     {pin_oe, key_level, key_press, key_release, sample_stb});
        else pass_cnt++;
        reset = 1'b0;
        wait_stb(c);
        total++;
        if (c !== FIRST) $display("FAIL midreset_stb: latency %0d expected %0d", c, FIRST);
        else pass_cnt++;
        wait_stb(c);
        total++;
        if (key_level !== 1'b0 || press_cnt !== p0)
            $display("FAIL midreset_early: level %b presses %0d expected 0 0", key_level, press_cnt - p0);
        else pass_cnt++;
        wait_stb(c);
        total++;
        if (key_level !== 1'b1) $display("FAIL midreset_level: got %b expected 1", key_level);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (key_press !== 1'b1) $display("FAIL midreset_pulse: got %b expected 1", key_press);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_first_stb();
        test_steady();
        test_clean_press();
        test_release();
        test_bounce();
        test_led_toggle();
        test_reset_mid();
        total++;
        if (both_cnt !== 0) $display("FAIL press_release_overlap: got %0d expected 0", both_cnt);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/key_led_reader.md
KEY_LED_READER -- requirements
Module: key_led_reader

Interface
REQ-001 Parameter SAMPLE_DIV, default 50000: key sample period in sys_clk cycles (1 ms at 50 MHz).
REQ-002 Parameter RELEASE_CYC, default 50: cycles the pad is released before sampling (settle time); legal range 4 .. SAMPLE_DIV-3.
REQ-003 Parameter DEBOUNCE_N, default 20: consecutive agreeing samples needed to change the debounced key state; legal range 1..255.
REQ-004 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 led_on  in  1  1 = LED on the shared pad requested lit.
REQ-007 pin_in  in  1  raw pad level (asynchronous); 0 = pad low (key pressed or LED driven).
REQ-008 pin_oe  out  1  1 = pad driven low (LED lit); 0 = pad released (high-Z, pulled up).
REQ-009 key_level  out  1  debounced key state; 1 = pressed.
REQ-010 key_press  out  1  one-cycle pulse on a debounced 0->1 transition of key_level.
REQ-011 key_release  out  1  one-cycle pulse on a debounced 1->0 transition of key_level.
REQ-012 sample_stb  out  1  one-cycle pulse in every cycle a key sample is taken.

Function
REQ-013 pin_in SHALL pass through a 2-flop synchronizer before any use; the synchronized bit is named pin_s.
REQ-014 A free-running divider SHALL count 0..SAMPLE_DIV-1 and wrap to 0; it SHALL never stall.
REQ-015 FSM states: DRIVE, RELEASE, SAMPLE.
REQ-016 DRIVE: pin_oe = led_on (combinational from the registered state, led_on used directly); transition to RELEASE in the cycle after the divider reads SAMPLE_DIV-1.
REQ-017 RELEASE: pin_oe = 0; a release counter counts RELEASE_CYC cycles; after the last one, go to SAMPLE.
REQ-018 SAMPLE: pin_oe = 0 for exactly one cycle; sample = ~pin_s (1 = pressed); sample_stb = 1; next state DRIVE.
REQ-019 Pad SHALL be released for exactly RELEASE_CYC+1 consecutive cycles per sample period; one sample per SAMPLE_DIV cycles.
REQ-020 led_on changes during RELEASE or SAMPLE SHALL NOT affect pin_oe until the return to DRIVE.
REQ-021 Debounce: on each sample, if sample == key_level, the agree counter clears to 0; otherwise it increments.
REQ-022 When the agree counter reaches DEBOUNCE_N, then key_level <= sample, the counter clears, and key_press or key_release pulses in the following cycle.
REQ-023 Agree counter width SHALL be 8 bits and SHALL never wrap, since it clears at DEBOUNCE_N.
REQ-024 Between samples, key_level and the agree counter SHALL hold their values.
REQ-025 key_press and key_release SHALL never be asserted in the same cycle; at most one of them pulses per sample.

Reset
REQ-026 While reset = 1: state = DRIVE, divider = 0, release counter = 0, agree counter = 0, synchronizer flops = 1.
REQ-027 While reset = 1: pin_oe = 0, key_level = 0, key_press = 0, key_release = 0, sample_stb = 0.
REQ-028 Reset asserted mid-RELEASE or mid-SAMPLE SHALL abort the cycle with no sample taken and no pulse emitted.
REQ-029 After reset deasserts, the first sample_stb SHALL occur SAMPLE_DIV+RELEASE_CYC+1 cycles later.

Verification (SAMPLE_DIV=100, RELEASE_CYC=8, DEBOUNCE_N=3)
REQ-030 Steady state: led_on=1, pin_in low when driven, high when released.
  -> pin_oe is 0 for 9 cycles out of every 100;
  -> sample_stb once per 100 cycles;
  -> key_level stays 0 and no pulses occur.
REQ-031 Clean press: hold pin_in=0 continuously from a given cycle.
  -> key_press pulses once on the cycle after the 3rd sample;
  -> key_level = 1 from then on.
REQ-032 Bounce: press samples alternate 1,1,0,1,1,1.
  -> key_press pulses only after the final three consecutive 1s (6th sample);
  -> no earlier pulse.
REQ-033 Release: with key_level=1, set pin_in=1 for 3 samples.
  -> key_release pulses once;
  -> key_level = 0;
  -> key_press stays 0 throughout.
REQ-034 led_on toggle: toggle led_on during RELEASE.
  -> pin_oe stays 0 until SAMPLE completes;
  -> pin_oe then follows led_on in DRIVE.
REQ-035 Reset mid-debounce: after 2 agreeing press samples, pulse reset for 1 cycle.
  -> all outputs 0;
  -> 3 fresh samples are required before key_press.
